// File: rtl/cnt_ldctrl_pkg.sv
// Shared types and default widths for the counter load sequencer.
package cnt_ldctrl_pkg;
   localparam int CL_DW      = 4;
   localparam int CL_DEPTH   = 4;
   localparam int CL_DWELL_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DWELL = 2'd2
   } state_t;

   typedef struct packed {
      logic [CL_DW-1:0]      value;
      logic [CL_DWELL_W-1:0] dwell;
   } req_entry_t;
endpackage

// File: rtl/cnt_ldctrl_fifo.sv
// Request FIFO: DEPTH entries of req_entry_t, pointer pair plus level counter.
module cnt_ldctrl_fifo
   import cnt_ldctrl_pkg::*;
#(
   parameter  int DEPTH = CL_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  req_entry_t    din,
   input  logic          pop,
   output req_entry_t    head,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   req_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [LW-1:0] level_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (level_r == LW'(DEPTH));
   assign empty     = (level_r == LW'(0));
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign head      = mem[rd_ptr_r];
   assign level     = level_r;

   // Pointers and level; simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= LW'(0);
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem[wr_ptr_r] <= din;
   end

endmodule

// File: rtl/counter_load_ctrl.sv
// Sequencer for a loadable up counter: queues {value, dwell} requests, issues one ld pulse
// per request, then free-runs for dwell cycles. Optional wrap flag: CNT_LDCTRL_WRAP_FLAG_EN.
module counter_load_ctrl
   import cnt_ldctrl_pkg::*;
#(
   parameter  int DW      = CL_DW,
   parameter  int DEPTH   = CL_DEPTH,
   parameter  int DWELL_W = CL_DWELL_W,
   localparam int LW      = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [DW-1:0]      req_value,
   input  logic [DWELL_W-1:0] req_dwell,
   output logic               ld,
   output logic [DW-1:0]      ldvalue,
   input  logic [DW-1:0]      dout,
   output logic               busy,
   output logic               done,
   output logic [LW-1:0]      fifo_level,
   output logic               wrap_flag
);

   state_t             state_r, state_nxt;
   logic [DWELL_W-1:0] dwell_r, dwell_nxt;
   logic               ld_r, ld_nxt;
   logic [DW-1:0]      ldvalue_r, ldvalue_nxt;
   logic               done_r, done_nxt;
   logic               push_s, pop_s;
   logic               fifo_full_s, fifo_empty_s;
   req_entry_t         din_s, head_s;

   // Ready comes from the registered level only, so a same-cycle pop never frees a slot.
   assign req_ready = !fifo_full_s;
   assign push_s    = req_valid && req_ready;
   assign din_s     = '{value: req_value, dwell: req_dwell};

   cnt_ldctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .din   (din_s),
      .pop   (pop_s),
      .head  (head_s),
      .level (fifo_level),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         dwell_r   <= DWELL_W'(0);
         ld_r      <= 1'b0;
         ldvalue_r <= DW'(0);
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         dwell_r   <= dwell_nxt;
         ld_r      <= ld_nxt;
         ldvalue_r <= ldvalue_nxt;
         done_r    <= done_nxt;
      end
   end

   // Next-state logic; ld_nxt is set only on the IDLE->LOAD step, so ld tracks LOAD exactly.
   always_comb begin
      state_nxt   = state_r;
      dwell_nxt   = dwell_r;
      ld_nxt      = 1'b0;
      ldvalue_nxt = ldvalue_r;
      done_nxt    = 1'b0;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s       = 1'b1;
               ld_nxt      = 1'b1;
               ldvalue_nxt = head_s.value;
               dwell_nxt   = head_s.dwell;
               state_nxt   = LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            if (dwell_r == DWELL_W'(0)) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = DWELL;
            end
         end
         DWELL: begin
            dwell_nxt = dwell_r - DWELL_W'(1);
            if (dwell_r == DWELL_W'(1)) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = DWELL;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ld      = ld_r;
   assign ldvalue = ldvalue_r;
   assign done    = done_r;
   assign busy    = (state_r != IDLE) || !fifo_empty_s;

`ifdef CNT_LDCTRL_WRAP_FLAG_EN
   logic wrap_r;

   // Sticky wrap: all-ones seen in DWELL means the counter rolls over on this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_r <= 1'b0;
      end else if (pop_s) begin
         wrap_r <= 1'b0;
      end else if ((state_r == DWELL) && (dout == {DW{1'b1}})) begin
         wrap_r <= 1'b1;
      end else begin
         wrap_r <= wrap_r;
      end
   end

   assign wrap_flag = wrap_r;
`else
   logic unused_dout;

   assign unused_dout = ^dout;
   assign wrap_flag   = 1'b0;
`endif

endmodule
